cache_control: RTL
==================

Name: cache_control

Overview:
- Controller FSM for the 2-way set-associative L1 cache.
- Sequences the hit check, LRU update, dirty-victim writeback and line allocation from physical memory.
- Drives the per-way load enables (load0/load1) and array-class loads (load_data_valid_dirty, load_tag). These feed the load-arbitration demux, which steers them to way 0 or way 1 arrays.
- Also keeps saturating hit/miss performance counters.

Parameters:
- CNT_WIDTH, 16, width of hit_count and miss_count.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  CPU read request, held until mem_resp
- mem_write  input  1  CPU write request, held until mem_resp
- hit0, hit1  input  1 each  tag match AND valid, per way, for the indexed set (combinational array read)
- valid0, valid1  input  1 each  valid bits of the indexed set
- dirty0, dirty1  input  1 each  dirty bits of the indexed set
- lru_out  input  1  LRU bit of the indexed set; value = least-recently-used way
- pmem_resp  input  1  physical memory done, one-cycle pulse
- mem_resp  output  1  CPU request complete
- pmem_read, pmem_write  output  1 each  physical memory strobes
- load0, load1  output  1 each  way enables to the load demux
- load_data_valid_dirty, load_tag, load_lru  output  1 each  array-class loads
- valid_in, dirty_in, lru_in  output  1 each  values written to the arrays
- data_sel  output  1  0 = CPU write-merged line, 1 = pmem line
- way_sel  output  1  way feeding the data-out and writeback mux
- pmem_addr_sel  output  1  0 = CPU address, 1 = {victim tag, index}
- hit_count, miss_count  output  CNT_WIDTH each  performance counters

Behaviour:
- State encoding: CHECK, WRITEBACK, ALLOCATE.
- Reset:
  - State goes to CHECK.
  - victim and refill registers clear to 0; counters clear to 0.
  - All outputs are combinational from state and inputs; in CHECK with no request, every strobe and load is 0.
- Reset mid-WRITEBACK or mid-ALLOCATE: the FSM returns to CHECK on the next edge and the pmem strobes drop that cycle. A late pmem_resp is ignored.
- Request priority: if mem_read and mem_write are both asserted, treat the request as a write. If hit0 and hit1 are both asserted, way 0 wins.
- CHECK with a hit (hit way h):
  - mem_resp=1, load_lru=1, lru_in=~h, all in the same cycle (zero-wait hit).
  - On a write, additionally: load_data_valid_dirty=1, load{h}=1, valid_in=1, dirty_in=1, data_sel=0.
  - hit_count increments (saturating) only if refill=0; refill then clears.
- CHECK with a miss (request present, no hit):
  - Victim = way 0 if !valid0; else way 1 if !valid1; else lru_out.
  - Register the victim; set refill=1; miss_count increments (saturating).
  - Next state = WRITEBACK if the victim is valid and dirty, else ALLOCATE.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim.
  - Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp, in the same cycle: load_data_valid_dirty=1, load_tag=1, load{victim}=1, valid_in=1, dirty_in=0, data_sel=1. Then go to CHECK.
  - The re-check hits, completes the request and is not counted as a hit.
- Request dropped mid-miss (illegal): the miss finishes and the FSM returns to CHECK idle.
- Counter saturation: saturate at 2^CNT_WIDTH-1; no wrap.
- Latencies:
  - Hit: 1 cycle.
  - Clean miss: 2 cycles + pmem latency.
  - Dirty miss: 3 cycles + 2× pmem latency.

Decomposition:
- Package lc3b_types gains cache_state_t (the enum above) and the constants WAY0=1'b0 and WAY1=1'b1.
- One sub-module: cache_sat_counter (parameterised width; inputs clk, rst, inc; output count, saturating). Instantiate it twice.
- Victim selection stays inline in the FSM.

Test Plan:
- Read hit, way 1 (hit1=1, lru_out=1) -> mem_resp the same cycle; load_lru=1, lru_in=0; hit_count=1; no pmem strobe.
- Write hit, way 0 -> the same cycle shows load_data_valid_dirty=1, load0=1, load1=0, dirty_in=1, data_sel=0, mem_resp=1.
- Clean miss, way 0 invalid; pmem_resp after 3 cycles -> ALLOCATE; the resp cycle shows load_tag=1, load_data_valid_dirty=1, load0=1, data_sel=1. Next cycle hit, mem_resp=1; miss_count=1, hit_count=0.
- Dirty miss, both ways valid, lru_out=1, dirty1=1 -> WRITEBACK with pmem_write=1, way_sel=1, pmem_addr_sel=1. pmem_resp -> ALLOCATE with pmem_read=1, load1 on resp -> mem_resp. No load before the writeback resp.
- rst asserted in the 2nd ALLOCATE cycle -> next cycle in CHECK, pmem_read=0, counters=0. A later pmem_resp causes no loads.
- CNT_WIDTH=2, 5 consecutive hits -> hit_count holds 3.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the L1 cache: controller state encoding and way identifiers.
package lc3b_types;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

endpackage

// File: rtl/cache_sat_counter.sv
// Saturating up-counter used for the cache hit/miss performance statistics.
module cache_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_control.sv
// Controller FSM for the 2-way set-associative L1 cache: hit check, LRU update,
// dirty-victim writeback, line allocation and hit/miss statistics.
module cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru_out,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 load0,
    output logic                 load1,
    output logic                 load_data_valid_dirty,
    output logic                 load_tag,
    output logic                 load_lru,
    output logic                 valid_in,
    output logic                 dirty_in,
    output logic                 lru_in,
    output logic                 data_sel,
    output logic                 way_sel,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    cache_state_t r_state;
    logic         r_victim;
    logic         r_refill;

    logic w_req;
    logic w_hit;
    logic w_hit_way;
    logic w_victim_next;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;

    assign w_req     = mem_read | mem_write;
    assign w_hit     = hit0 | hit1;
    assign w_hit_way = hit0 ? WAY0 : WAY1;

    // Fill an invalid way first; only evict by LRU when the set is full.
    assign w_victim_next  = !valid0 ? WAY0 : (!valid1 ? WAY1 : lru_out);
    assign w_victim_dirty = (w_victim_next == WAY0) ? (valid0 & dirty0) : (valid1 & dirty1);

    assign w_hit_inc  = (r_state == CHECK) && w_req && w_hit && !r_refill;
    assign w_miss_inc = (r_state == CHECK) && w_req && !w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CHECK;
            r_victim <= WAY0;
            r_refill <= 1'b0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (w_req && w_hit) begin
                        r_refill <= 1'b0;
                    end else if (w_req) begin
                        r_victim <= w_victim_next;
                        r_refill <= 1'b1;
                        r_state  <= w_victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) r_state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (pmem_resp) r_state <= CHECK;
                end
                default: r_state <= CHECK;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        mem_resp              = 1'b0;
        pmem_read             = 1'b0;
        pmem_write            = 1'b0;
        load0                 = 1'b0;
        load1                 = 1'b0;
        load_data_valid_dirty = 1'b0;
        load_tag              = 1'b0;
        load_lru              = 1'b0;
        valid_in              = 1'b0;
        dirty_in              = 1'b0;
        lru_in                = 1'b0;
        data_sel              = 1'b0;
        way_sel               = w_hit_way;
        pmem_addr_sel         = 1'b0;
        case (r_state)
            CHECK: begin
                if (w_req && w_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~w_hit_way;
                    if (mem_write) begin
                        load_data_valid_dirty = 1'b1;
                        load0                 = (w_hit_way == WAY0);
                        load1                 = (w_hit_way == WAY1);
                        valid_in              = 1'b1;
                        dirty_in              = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = r_victim;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = r_victim;
                if (pmem_resp) begin
                    load_data_valid_dirty = 1'b1;
                    load_tag              = 1'b1;
                    load0                 = (r_victim == WAY0);
                    load1                 = (r_victim == WAY1);
                    valid_in              = 1'b1;
                    data_sel              = 1'b1;
                end
            end
            default: ;
        endcase
    end

    cache_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    cache_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

endmodule
